// File: rtl/hazard_md_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_md_ctrl
//
// Central hazard controller for a 5-stage MIPS pipeline (F/D/E/M/W).
//
// The decode-stage source registers are compared against the destination
// registers of the E, M and W stages. Each stage's Tnew (cycles until its
// result exists) is weighed against D's Tuse (cycles until D needs the
// operand). From that the block produces:
//   - a stall that freezes the PC and the D register,
//   - a bubble request (E_clr) that clears the E register,
//   - forwarding selects for the two decode operands.
//
// It also sequences the multi-cycle mult/div unit with an IDLE/BUSY state
// machine and keeps a saturating count of stalled cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   D_rs/D_rt    decode source registers
//   D_tuse_rs/rt cycles until D needs rs/rt (3 = operand not used)
//   D_md_use     D instruction uses the mult/div unit or HI/LO
//   E_wa/E_tnew  E-stage destination register and its Tnew
//   M_wa/M_tnew  M-stage destination register and its Tnew
//   W_wa         W-stage destination register (its Tnew is always 0)
//   E_md_start   valid mult/div instruction in E this cycle
//   E_md_is_div  1 = div/divu, 0 = mult/multu (qualifies E_md_start)
//   stall        hold PC and D register
//   E_clr        load a bubble into E on the next edge (equals stall)
//   fwd_rs/rt    operand source: 0 = regfile, 1 = W, 2 = M, 3 = E
//   md_busy      mult/div unit is busy
//   stall_cnt    saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module hazard_md_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md_use,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic [4:0]       W_wa,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             stall,
  output logic             E_clr,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Busy counter must hold the longer of the two latencies.
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_CW  = $clog2(MD_MAX + 1);

  localparam logic [MD_CW-1:0] MULT_LAT_C = MD_CW'(MULT_LAT);
  localparam logic [MD_CW-1:0] DIV_LAT_C  = MD_CW'(DIV_LAT);
  localparam logic [MD_CW-1:0] MD_ONE_C   = MD_CW'(1);
  localparam logic [MD_CW-1:0] MD_ZERO_C  = {MD_CW{1'b0}};

  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // A stage "matches" a source when the source is a real register
  // ($0 never matches) and equals that stage's destination.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic [4:0] dst);
    reg_match = (src != 5'd0) && (src == dst);
  endfunction

  // Stall when a producer in E or M will not have its result ready
  // before the consumer in D needs it (Tuse < Tnew).
  function automatic logic data_stall(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] e_wa,
                                      input logic [1:0] e_tnew,
                                      input logic [4:0] m_wa,
                                      input logic [1:0] m_tnew);
    data_stall = (reg_match(src, e_wa) && (tuse < e_tnew)) ||
                 (reg_match(src, m_wa) && (tuse < m_tnew));
  endfunction

  // Youngest matching stage decides. A younger match whose value is not
  // ready yet must not fall through to an older (stale) copy: it selects
  // the regfile and the stall logic holds D until the value is ready.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] e_wa,
                                         input logic [1:0] e_tnew,
                                         input logic [4:0] m_wa,
                                         input logic [1:0] m_tnew,
                                         input logic [4:0] w_wa);
    if (reg_match(src, e_wa)) begin
      fwd_sel = (e_tnew == 2'd0) ? 2'd3 : 2'd0;
    end else if (reg_match(src, m_wa)) begin
      fwd_sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    end else if (reg_match(src, w_wa)) begin
      fwd_sel = 2'd1;
    end else begin
      fwd_sel = 2'd0;
    end
  endfunction

  // -------------------------------------------------------------------------
  // Internal signals
  // -------------------------------------------------------------------------
  md_state_t        md_state_r;
  md_state_t        md_state_nxt_s;
  logic [MD_CW-1:0] md_cnt_r;
  logic [MD_CW-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;

  logic             stall_rs_s;
  logic             stall_rt_s;
  logic             md_stall_s;
  logic             stall_s;
  logic             md_busy_s;

  // -------------------------------------------------------------------------
  // Hazard detection and forwarding
  // -------------------------------------------------------------------------

  // Combine data and mult/div interlocks into the pipeline stall.
  always_comb begin
    md_busy_s  = (md_state_r == MD_BUSY);
    stall_rs_s = data_stall(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
    stall_rt_s = data_stall(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
    // An instruction entering E this cycle already occupies the unit.
    md_stall_s = D_md_use && (md_busy_s || E_md_start);
    stall_s    = stall_rs_s || stall_rt_s || md_stall_s;
  end

  // Drive the stall, bubble and forwarding outputs.
  always_comb begin
    stall  = stall_s;
    E_clr  = stall_s;
    fwd_rs = fwd_sel(D_rs, E_wa, E_tnew, M_wa, M_tnew, W_wa);
    fwd_rt = fwd_sel(D_rt, E_wa, E_tnew, M_wa, M_tnew, W_wa);
  end

  // -------------------------------------------------------------------------
  // Mult/div busy state machine
  // -------------------------------------------------------------------------

  // Mult/div state and latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_r <= MD_IDLE;
      md_cnt_r   <= MD_ZERO_C;
    end else begin
      md_state_r <= md_state_nxt_s;
      md_cnt_r   <= md_cnt_nxt_s;
    end
  end

  // Next-state logic: load latency on start, count down while busy.
  always_comb begin
    md_state_nxt_s = md_state_r;
    md_cnt_nxt_s   = md_cnt_r;
    case (md_state_r)
      MD_IDLE: begin
        if (E_md_start) begin
          md_state_nxt_s = MD_BUSY;
          md_cnt_nxt_s   = E_md_is_div ? DIV_LAT_C : MULT_LAT_C;
        end else begin
          md_state_nxt_s = MD_IDLE;
          md_cnt_nxt_s   = MD_ZERO_C;
        end
      end
      MD_BUSY: begin
        // A start seen while busy is ignored; decode interlock keeps it
        // from happening in a correct pipeline.
        if (md_cnt_r <= MD_ONE_C) begin
          md_state_nxt_s = MD_IDLE;
          md_cnt_nxt_s   = MD_ZERO_C;
        end else begin
          md_state_nxt_s = MD_BUSY;
          md_cnt_nxt_s   = md_cnt_r - MD_ONE_C;
        end
      end
      default: begin
        md_state_nxt_s = MD_IDLE;
        md_cnt_nxt_s   = MD_ZERO_C;
      end
    endcase
  end

  assign md_busy = md_busy_s;

  // -------------------------------------------------------------------------
  // Stall performance counter
  // -------------------------------------------------------------------------

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= CNT_ZERO_C;
    end else if (stall_s && (stall_cnt_r != CNT_MAX_C)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_md_ctrl
//
// Self-checking bench for hazard_md_ctrl. A behavioural reference model
// (stage tables scanned youngest-first, an integer count of remaining busy
// cycles and an integer stall count) is compared every cycle against the
// DUT. Directed scenarios cover load-use, forwarding priority, register $0,
// mult/div busy length, reset during a divide and counter saturation; a
// randomized run with occasional resets follows.
// ---------------------------------------------------------------------------
module tb_hazard_md_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic [1:0]       D_tuse_rs;
  logic [1:0]       D_tuse_rt;
  logic             D_md_use;
  logic [4:0]       E_wa;
  logic [1:0]       E_tnew;
  logic [4:0]       M_wa;
  logic [1:0]       M_tnew;
  logic [4:0]       W_wa;
  logic             E_md_start;
  logic             E_md_is_div;
  logic             stall;
  logic             E_clr;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_errors;

  // Reference model state.
  int md_left;     // remaining busy cycles of the mult/div unit
  int cnt_model;   // expected stall count

  // Observations from the most recent cycle.
  logic last_stall;
  logic last_busy;

  hazard_md_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_tuse_rs   (D_tuse_rs),
    .D_tuse_rt   (D_tuse_rt),
    .D_md_use    (D_md_use),
    .E_wa        (E_wa),
    .E_tnew      (E_tnew),
    .M_wa        (M_wa),
    .M_tnew      (M_tnew),
    .W_wa        (W_wa),
    .E_md_start  (E_md_start),
    .E_md_is_div (E_md_is_div),
    .stall       (stall),
    .E_clr       (E_clr),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected data stall for one operand.
  function automatic bit exp_data_stall(input int src, input int tuse);
    if (src == 0) return 1'b0;
    return ((src == int'(E_wa)) && (tuse < int'(E_tnew))) ||
           ((src == int'(M_wa)) && (tuse < int'(M_tnew)));
  endfunction

  // Expected forwarding code: scan stages youngest first; the first
  // holder of the register decides (ready -> its code, else regfile).
  function automatic int exp_fwd(input int src);
    int wa[3];
    int tn[3];
    wa[0] = int'(E_wa); tn[0] = int'(E_tnew);
    wa[1] = int'(M_wa); tn[1] = int'(M_tnew);
    wa[2] = int'(W_wa); tn[2] = 0;
    if (src == 0) return 0;
    for (int s = 0; s < 3; s++) begin
      if (wa[s] == src) return (tn[s] == 0) ? (3 - s) : 0;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_md_use = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0;
    M_tnew = 2'd0; W_wa = 5'd0; E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  // One clock cycle: compare against the model, then advance the model.
  // Entered and left just after a falling edge.
  task automatic cycle();
    bit e_stall;
    #1;
    e_stall = exp_data_stall(int'(D_rs), int'(D_tuse_rs)) ||
              exp_data_stall(int'(D_rt), int'(D_tuse_rt)) ||
              (D_md_use && ((md_left > 0) || E_md_start));
    check_val("stall",     32'(stall),     32'(e_stall));
    check_val("E_clr",     32'(E_clr),     32'(e_stall));
    check_val("fwd_rs",    32'(fwd_rs),    32'(exp_fwd(int'(D_rs))));
    check_val("fwd_rt",    32'(fwd_rt),    32'(exp_fwd(int'(D_rt))));
    check_val("md_busy",   32'(md_busy),   32'(md_left > 0));
    check_val("stall_cnt", 32'(stall_cnt), 32'(cnt_model));
    last_stall = stall;
    last_busy  = md_busy;
    @(posedge clk);
    if (reset) begin
      md_left   = 0;
      cnt_model = 0;
    end else begin
      if (md_left > 0) md_left--;
      else if (E_md_start) md_left = E_md_is_div ? DIV_LAT : MULT_LAT;
      if (e_stall && cnt_model < CNT_MAX) cnt_model++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int busy_seen;
  int stall_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();

    // Initial reset: DUT state is unknown until the first reset edge.
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    md_left   = 0;
    cnt_model = 0;
    #1;
    check_val("rst_md_busy",   32'(md_busy),   32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst_stall",     32'(stall),     32'd0);

    // Load-use: E has a load result two cycles out, D needs rs in one.
    E_wa = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd1;
    #1;
    check_val("lu_stall", 32'(stall), 32'd1);
    check_val("lu_E_clr", 32'(E_clr), 32'd1);
    cycle();
    E_wa = 5'd0; M_wa = 5'd8; M_tnew = 2'd1;
    #1;
    check_val("lu2_stall", 32'(stall), 32'd0);
    check_val("lu2_fwd",   32'(fwd_rs), 32'd0);
    cycle();
    M_tnew = 2'd0;
    #1;
    check_val("lu3_fwd", 32'(fwd_rs), 32'd2);
    cycle();

    // Forwarding priority E > M > W.
    clear_inputs();
    E_wa = 5'd9; M_wa = 5'd9; W_wa = 5'd9; D_rt = 5'd9; D_tuse_rt = 2'd0;
    #1;
    check_val("pri_E", 32'(fwd_rt), 32'd3);
    cycle();
    E_wa = 5'd0;
    #1;
    check_val("pri_M", 32'(fwd_rt), 32'd2);
    cycle();
    M_wa = 5'd0;
    #1;
    check_val("pri_W", 32'(fwd_rt), 32'd1);
    cycle();

    // Register $0 never stalls or forwards.
    clear_inputs();
    D_rs = 5'd0; E_wa = 5'd0; E_tnew = 2'd2; D_tuse_rs = 2'd0; W_wa = 5'd0;
    #1;
    check_val("zero_stall", 32'(stall),  32'd0);
    check_val("zero_fwd",   32'(fwd_rs), 32'd0);
    cycle();

    // Mult: busy for MULT_LAT cycles, stall for start cycle + MULT_LAT.
    clear_inputs();
    apply_reset();
    D_md_use = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b0;
    cycle();
    busy_seen  = int'(last_busy);
    stall_seen = int'(last_stall);
    E_md_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      busy_seen  += int'(last_busy);
      stall_seen += int'(last_stall);
    end
    check_val("mult_busy_len",  32'(busy_seen),  32'd5);
    check_val("mult_stall_len", 32'(stall_seen), 32'd6);
    check_val("mult_stall_cnt", 32'(stall_cnt),  32'd6);

    // Div aborted by reset on its 4th busy cycle, then a fresh mult.
    clear_inputs();
    apply_reset();
    D_md_use = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b1;
    cycle();
    E_md_start = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check_val("div_rst_busy", 32'(md_busy),   32'd0);
    check_val("div_rst_cnt",  32'(stall_cnt), 32'd0);
    E_md_start = 1'b1; E_md_is_div = 1'b0;
    cycle();
    E_md_start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      busy_seen += int'(last_busy);
    end
    check_val("post_rst_mult_busy", 32'(busy_seen), 32'd5);

    // Saturation: continuous data stall for longer than the counter range.
    clear_inputs();
    apply_reset();
    E_wa = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
    for (int i = 0; i < 20; i++) cycle();
    check_val("sat_cnt", 32'(stall_cnt), 32'd15);

    // Randomized run against the model.
    clear_inputs();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      D_rs        = 5'($urandom_range(0, 3));
      D_rt        = 5'($urandom_range(0, 3));
      D_tuse_rs   = 2'($urandom_range(0, 3));
      D_tuse_rt   = 2'($urandom_range(0, 3));
      D_md_use    = ($urandom_range(0, 3) == 0);
      E_wa        = 5'($urandom_range(0, 3));
      E_tnew      = 2'($urandom_range(0, 3));
      M_wa        = 5'($urandom_range(0, 3));
      M_tnew      = 2'($urandom_range(0, 3));
      W_wa        = 5'($urandom_range(0, 3));
      E_md_start  = ($urandom_range(0, 5) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
